// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, row-base table and FSM state type for the LCD text controller
package lcd_pkg;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] SET_DDRAM = 8'h80;
    localparam logic [7:0] SPACE     = 8'h20;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_ROW_ADDR,
        ST_CHAR,
        ST_FRAME_END
    } state_e;

    // DDRAM start address of each display row (HD44780 4-line layout)
    function automatic logic [7:0] row_base(input logic [1:0] r);
        logic [7:0] b;
        case (r)
            2'd0:    b = 8'h00;
            2'd1:    b = 8'h40;
            2'd2:    b = 8'h14;
            default: b = 8'h54;
        endcase
        return b;
    endfunction

    // Init command sequence, in issue order
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = FUNC_SET;
            2'd1:    c = DISP_ON;
            2'd2:    c = CLEAR;
            default: c = ENTRY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// rtl/lcd_text_ctrl_if.sv - host character write port
interface lcd_text_ctrl_if;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [5:0] wr_col;
    logic [7:0] wr_char;

    modport master (output wr_en, wr_row, wr_col, wr_char);
    modport slave  (input  wr_en, wr_row, wr_col, wr_char);
endinterface

// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - one HD44780 byte transfer: setup, enable pulse, post-byte wait
module lcd_bus_writer #(
    parameter int EN_CYC  = 16,
    parameter int CMD_CYC = 2000,
    parameter int CLR_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data_in,
    input  logic       long_wait,
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    logic        busy_q, busy_d;
    logic        long_q, long_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] last_cnt;

    // Final cycle index of the transfer: setup + enable + low + wait
    always_comb begin
        last_cnt = long_q ? 32'(EN_CYC + 1 + CLR_CYC) : 32'(EN_CYC + 1 + CMD_CYC);
    end

    // done marks the last wait cycle so a new start can follow with no gap
    assign done = busy_q && (cnt_q == last_cnt);

    // Transfer sequencing; RS/DATA are latched once and held for the whole transfer
    always_comb begin
        busy_d = busy_q;
        long_d = long_q;
        rs_d   = rs_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = 32'd0;
            rs_d   = rs;
            data_d = data_in;
            long_d = long_wait;
        end else if (busy_q) begin
            if (done) begin
                busy_d = 1'b0;
                cnt_d  = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
        e_d = busy_d && (cnt_d >= 32'd1) && (cnt_d <= 32'(EN_CYC));
    end

    // Registered pins so reset clears them immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            long_q <= 1'b0;
            e_q    <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            cnt_q  <= 32'd0;
        end else begin
            busy_q <= busy_d;
            long_q <= long_d;
            e_q    <= e_d;
            rs_q   <= rs_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - character buffer and refresh FSM driving an HD44780 text LCD
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int ROWS    = 2,
    parameter int COLS    = 16,
    parameter int EN_CYC  = 16,
    parameter int CMD_CYC = 2000,
    parameter int CLR_CYC = 82000,
    parameter int PWR_CYC = 750000
) (
    input  logic              iCLK_50MHZ,
    input  logic              iRST_N,
    lcd_text_ctrl_if.slave    wr,
    output logic              init_done,
    output logic              frame_done,
    output logic [7:0]        LCD_DATA,
    output logic              LCD_RW,
    output logic              LCD_E,
    output logic              LCD_RS
);

    localparam int CELLS = ROWS * COLS;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    if (CLK_HZ <= 0 || ROWS < 1 || ROWS > 4 || COLS < 8 || COLS > 40 || PWR_CYC < CELLS) begin : g_bad_params
        $error("lcd_text_ctrl: parameter out of range");
    end

    state_e          state_q, state_d;
    logic [31:0]     pwr_cnt_q, pwr_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [1:0]      row_q, row_d;
    logic [5:0]      col_q, col_d;
    logic            init_done_q, init_done_d;
    logic            frame_done_q, frame_done_d;
    logic [IW-1:0]   fill_idx_q, fill_idx_d;
    logic            fill_busy_q, fill_busy_d;
    logic [CELLS-1:0] written_q, written_d;

    logic [7:0]      buf_mem [CELLS];
    logic            host_ok;
    logic [IW-1:0]   host_idx;
    logic            fill_we;
    logic [IW-1:0]   rd_idx;
    logic [7:0]      rd_data;

    logic            wb_start, wb_rs, wb_long, wb_busy, wb_done, wb_ready;
    logic [7:0]      wb_data;

    // Host write decode; out-of-range coordinates never touch the buffer
    always_comb begin
        host_ok  = wr.wr_en && (32'(wr.wr_row) < 32'(ROWS)) && (32'(wr.wr_col) < 32'(COLS));
        host_idx = IW'(32'(wr.wr_row) * 32'(COLS) + 32'(wr.wr_col));
        rd_idx   = IW'(32'(row_q) * 32'(COLS) + 32'(col_q));
        rd_data  = buf_mem[rd_idx];
    end

    // Space fill after reset; cells already written by the host are skipped
    always_comb begin
        written_d   = written_q;
        fill_idx_d  = fill_idx_q;
        fill_busy_d = fill_busy_q;
        fill_we     = fill_busy_q && !written_q[fill_idx_q] && !(host_ok && (host_idx == fill_idx_q));
        if (host_ok) begin
            written_d[host_idx] = 1'b1;
        end
        if (fill_busy_q) begin
            if (fill_idx_q == IW'(CELLS - 1)) begin
                fill_busy_d = 1'b0;
            end else begin
                fill_idx_d = fill_idx_q + 1'b1;
            end
        end
    end

    // Character buffer storage; contents are rebuilt by the fill, so no reset
    always_ff @(posedge iCLK_50MHZ) begin
        if (fill_we) begin
            buf_mem[fill_idx_q] <= SPACE;
        end
        if (host_ok) begin
            buf_mem[host_idx] <= wr.wr_char;
        end
    end

    assign wb_ready = !wb_busy || wb_done;

    // Refresh FSM: each state names the next byte to issue; issuing on done keeps bytes back-to-back
    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        idx_d        = idx_q;
        row_d        = row_q;
        col_d        = col_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        wb_start     = 1'b0;
        wb_rs        = 1'b0;
        wb_data      = 8'h00;
        wb_long      = 1'b0;
        unique case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_cnt_q == 32'(PWR_CYC - 1)) begin
                    pwr_cnt_d = 32'd0;
                    idx_d     = 3'd0;
                    state_d   = ST_INIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 32'd1;
                end
            end
            ST_INIT: begin
                if (idx_q != 3'd4) begin
                    if (wb_ready) begin
                        wb_start = 1'b1;
                        wb_data  = init_cmd(idx_q[1:0]);
                        wb_long  = (idx_q == 3'd2);
                        idx_d    = idx_q + 3'd1;
                    end
                end else if (wb_done) begin
                    init_done_d = 1'b1;
                    row_d       = 2'd0;
                    col_d       = 6'd0;
                    state_d     = ST_ROW_ADDR;
                end
            end
            ST_ROW_ADDR: begin
                if (wb_ready) begin
                    wb_start = 1'b1;
                    wb_data  = SET_DDRAM | row_base(row_q);
                    col_d    = 6'd0;
                    state_d  = ST_CHAR;
                end
            end
            ST_CHAR: begin
                if (wb_ready) begin
                    wb_start = 1'b1;
                    wb_rs    = 1'b1;
                    wb_data  = rd_data;
                    if (col_q == 6'(COLS - 1)) begin
                        col_d = 6'd0;
                        if (row_q == 2'(ROWS - 1)) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_FRAME_END;
                        end else begin
                            row_d   = row_q + 2'd1;
                            state_d = ST_ROW_ADDR;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            ST_FRAME_END: begin
                row_d   = 2'd0;
                state_d = ST_ROW_ADDR;
            end
            default: begin
                state_d = ST_PWR_WAIT;
            end
        endcase
    end

    // Control registers with asynchronous clear
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= ST_PWR_WAIT;
            pwr_cnt_q    <= 32'd0;
            idx_q        <= 3'd0;
            row_q        <= 2'd0;
            col_q        <= 6'd0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            fill_idx_q   <= '0;
            fill_busy_q  <= 1'b1;
            written_q    <= '0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            fill_idx_q   <= fill_idx_d;
            fill_busy_q  <= fill_busy_d;
            written_q    <= written_d;
        end
    end

    lcd_bus_writer #(
        .EN_CYC  (EN_CYC),
        .CMD_CYC (CMD_CYC),
        .CLR_CYC (CLR_CYC)
    ) u_bus_writer (
        .clk       (iCLK_50MHZ),
        .rst_n     (iRST_N),
        .start     (wb_start),
        .rs        (wb_rs),
        .data_in   (wb_data),
        .long_wait (wb_long),
        .busy      (wb_busy),
        .done      (wb_done),
        .lcd_e     (LCD_E),
        .lcd_rs    (LCD_RS),
        .lcd_data  (LCD_DATA)
    );

    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
    assign LCD_RW     = 1'b0;

endmodule

// File: doc/lcd_text_ctrl.md
LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

Interface
REQ-001 Parameters, one per line:
- CLK_HZ, 50000000, clock frequency, documentation only.
- ROWS, 2, display rows, 1..4.
- COLS, 16, characters per row, 8..40.
- EN_CYC, 16, LCD_E high width in cycles.
- CMD_CYC, 2000, post-byte wait in cycles (40 us).
- CLR_CYC, 82000, post-clear wait in cycles (1.64 ms).
- PWR_CYC, 750000, power-up wait in cycles (15 ms).
REQ-002 Ports, one per line:
- iCLK_50MHZ, in, 1, clock.
- iRST_N, in, 1, asynchronous active-low reset.
- wr_en, in, 1, host character write strobe.
- wr_row, in, 2, target row.
- wr_col, in, 6, target column.
- wr_char, in, 8, ASCII code.
- init_done, out, 1, init sequence complete.
- frame_done, out, 1, one-cycle pulse after the last character of the last row.
- LCD_DATA, out, 8, HD44780 data bus (write-only).
- LCD_RW, out, 1, constant 0.
- LCD_E, out, 1, enable strobe.
- LCD_RS, out, 1, 0 = command, 1 = data.
REQ-003 One clock, iCLK_50MHZ; reset iRST_N is asynchronous and active-low.

Function
REQ-004 Internal buffer: ROWS*COLS bytes; wr_en=1 writes wr_char at (wr_row, wr_col) on the same rising edge, with no backpressure.
REQ-005 Writes with wr_row>=ROWS or wr_col>=COLS are ignored and leave the buffer unchanged.
REQ-006 FSM states and transitions:
- PWR_WAIT (PWR_CYC cycles) -> INIT.
- INIT -> ROW_ADDR.
- ROW_ADDR -> CHAR.
- CHAR -> ROW_ADDR (next row) or FRAME_END (last row).
- FRAME_END -> ROW_ADDR (row 0), in an endless refresh loop.
REQ-007 INIT sends commands 0x38, 0x0C, 0x01, 0x06 in order, with RS=0; init_done rises one cycle after the 0x06 wait completes.
REQ-008 ROW_ADDR sends command 0x80|base[r], with RS=0; base = {0x00, 0x40, 0x14, 0x54} for r = 0..3.
REQ-009 CHAR sends buffer[r][0..COLS-1] in column order, with RS=1.
REQ-010 Byte transfer timing:
- Cycle 0: LCD_RS and LCD_DATA driven, LCD_E=0.
- Cycles 1..EN_CYC: LCD_E=1.
- Cycle EN_CYC+1: LCD_E=0.
- Then wait CMD_CYC cycles (CLR_CYC after 0x01) before the next byte.
- LCD_RS and LCD_DATA are stable from cycle 0 through the end of the wait.
REQ-011 A character byte is sampled from the buffer at cycle 0 of its transfer; a write landing in the same cell on the same or a later cycle appears in the next frame.
REQ-012 frame_done pulses for exactly one cycle on FRAME_END entry; its period equals ROWS*(COLS+1)*(EN_CYC+2+CMD_CYC) cycles.
REQ-013 No command other than 0x80|base is issued after INIT; the display is never re-cleared during refresh.

Reset
REQ-014 iRST_N low asynchronously forces the following, including mid-transfer:
- LCD_E=0, LCD_RS=0, LCD_DATA=0x00, LCD_RW=0;
- init_done=0, frame_done=0;
- state PWR_WAIT, all counters 0.
REQ-015 On reset, the buffer is filled with 0x20 (space) at one cell per cycle during PWR_WAIT, completing before INIT (PWR_CYC >= ROWS*COLS); host writes during the fill are accepted and override the fill.

Structure
REQ-016 Shared package lcd_pkg holds:
- command constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, SET_DDRAM 0x80);
- the row-base table;
- the FSM state enum.
REQ-017 Sub-module lcd_bus_writer implements REQ-010: start/rs/byte/long_wait in, done pulse out, LCD pins out. lcd_text_ctrl holds the FSM and the buffer.

Verification
Bench uses EN_CYC=4, CMD_CYC=10, CLR_CYC=30, PWR_CYC=64, ROWS=2, COLS=16, unless stated otherwise.
REQ-018 Init sequence:
- Stimulus: release reset.
- Required: LCD_E stays low for 64 cycles; then bytes 0x38, 0x0C, 0x01, 0x06 with RS=0; 30-cycle gap after 0x01; init_done rises.
REQ-019 Character update:
- Stimulus: write 'A' (0x41) to (1,5).
- Required: in the next frame, the sixth data byte after command 0xC0 is 0x41; all other data bytes are 0x20.
REQ-020 Out-of-range and collision:
- Stimulus: write to (2,0) and to (0,16); then write to (0,3) during the transfer of (0,3).
- Required: the out-of-range writes are absent from the frame; the colliding write appears in the following frame.
REQ-021 Reset mid-transfer:
- Stimulus: assert iRST_N low while LCD_E=1.
- Required: LCD_E=0 before the next clock edge; after release, the full init sequence is repeated.
REQ-022 Frame period and row addressing:
- Stimulus: ROWS=4, COLS=20.
- Required: frame_done period is 4*21*16 = 1344 cycles; row commands are 0x80, 0xC0, 0x94, 0xD4.
